// File: rtl/uart_config_pkg.sv
// uart_config_pkg: shared constants for the UART control-register block.
// Parity encoding, stop-bit encoding, config-word bit positions and the
// default config register address.
package uart_config_pkg;

    // Parity mode encoding as seen on paritybit
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;
    localparam logic [1:0] PAR_RSVD = 2'b11;

    // Stop-bit encoding as seen on stopbit
    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

    // Bit positions inside an 8-bit config word
    localparam int STOP_VAL_BIT = 7;
    localparam int STOP_WE_BIT  = 6;
    localparam int PAR_WE_BIT   = 5;
    localparam int PAR_VAL_MSB  = 3;
    localparam int PAR_VAL_LSB  = 2;

    // Default address of the config register
    localparam logic [1:0] CFG_ADDR_DFLT = 2'b01;

endpackage

// File: rtl/uart_config_if.sv
// uart_config_if: host write port of the UART config block
// (valid/ready handshake carrying a 2-bit address and 8-bit data).
interface uart_config_if;

    logic       c_valid;
    logic [1:0] c_addr;
    logic [7:0] c_data;
    logic       c_ready;

    // Host side: issues writes
    modport master (
        output c_valid,
        output c_addr,
        output c_data,
        input  c_ready
    );

    // Register block side: accepts writes
    modport slave (
        input  c_valid,
        input  c_addr,
        input  c_data,
        output c_ready
    );

endinterface

// File: rtl/uart_config.sv
// uart_config: control registers holding parity mode and stop-bit count
// for the UART TX/RX datapaths. Writes arrive over a valid/ready port and
// take effect on the accepting clock edge; all outputs are registered.
// Optional feature macro: UART_CONFIG_ERR_EN adds a registered c_err pulse
// for writes to an unknown address or with a reserved parity value.
module uart_config
    import uart_config_pkg::*;
#(
    parameter logic [1:0] CFG_ADDR   = CFG_ADDR_DFLT,
    parameter logic [1:0] PARITY_RST = PAR_NONE,
    parameter logic       STOP_RST   = STOP_1
) (
    input  logic           clk,
    input  logic           rst,
    uart_config_if.slave   cfg,
    output logic [1:0]     paritybit,
`ifdef UART_CONFIG_ERR_EN
    output logic           stopbit,
    output logic           c_err
`else
    output logic           stopbit
`endif
);

    logic       ready_reg;
    logic [1:0] parity_reg;
    logic [1:0] parity_next;
    logic       stop_reg;
    logic       stop_next;

    logic       accept;
    logic       addr_hit;
    logic       par_we;
    logic [1:0] par_val;
    logic       stop_we;
    logic       stop_val;
    logic       par_rsvd;

    // Reserved data bits carry no meaning; fold them into a sink net.
    logic       unused_data_bits;
    assign unused_data_bits = ^{cfg.c_data[4], cfg.c_data[1:0]};

    // Field decode of the incoming word
    assign accept   = cfg.c_valid & ready_reg;
    assign addr_hit = (cfg.c_addr == CFG_ADDR);
    assign par_we   = cfg.c_data[PAR_WE_BIT];
    assign par_val  = cfg.c_data[PAR_VAL_MSB:PAR_VAL_LSB];
    assign stop_we  = cfg.c_data[STOP_WE_BIT];
    assign stop_val = cfg.c_data[STOP_VAL_BIT];
    assign par_rsvd = par_we & (par_val == PAR_RSVD);

    // Next-state of the config fields; a reserved parity value is dropped
    // while the stop field of the same word still applies.
    always_comb begin
        parity_next = parity_reg;
        stop_next   = stop_reg;
        if (accept && addr_hit) begin
            if (par_we && !par_rsvd) begin
                parity_next = par_val;
            end
            if (stop_we) begin
                stop_next = stop_val;
            end
        end
    end

    // Config and ready registers; reset overrides any concurrent write
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_reg  <= 1'b0;
            parity_reg <= PARITY_RST;
            stop_reg   <= STOP_RST;
        end else begin
            ready_reg  <= 1'b1;
            parity_reg <= parity_next;
            stop_reg   <= stop_next;
        end
    end

`ifdef UART_CONFIG_ERR_EN
    logic err_reg;
    logic err_next;

    // Flag writes that could not be honoured in full
    always_comb begin
        err_next = accept & (!addr_hit | par_rsvd);
    end

    // One-cycle error pulse following the offending write
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign c_err = err_reg;
`endif

    assign cfg.c_ready = ready_reg;
    assign paritybit   = parity_reg;
    assign stopbit     = stop_reg;

endmodule

// File: tb/tb_uart_config.sv
// tb_uart_config: directed self-checking bench for uart_config.
// Each step drives one cycle of stimulus, waits for the edge and checks
// the registered outputs against hand-computed values.
`timescale 1ns/1ps
module tb_uart_config;

    logic       clk;
    logic       rst;
    logic [1:0] paritybit;
    logic       stopbit;
`ifdef UART_CONFIG_ERR_EN
    logic       c_err;
`endif

    int n_checks;
    int n_fail;

    uart_config_if cfg_bus ();

    uart_config dut (
        .clk       (clk),
        .rst       (rst),
        .cfg       (cfg_bus.slave),
        .paritybit (paritybit),
`ifdef UART_CONFIG_ERR_EN
        .stopbit   (stopbit),
        .c_err     (c_err)
`else
        .stopbit   (stopbit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then compare outputs 1 ns after the rising edge.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [1:0] a, input logic [7:0] d,
                        input logic [1:0] e_par, input logic e_stop,
                        input logic e_ready, input logic e_err);
        rst             = r;
        cfg_bus.c_valid = v;
        cfg_bus.c_addr  = a;
        cfg_bus.c_data  = d;
        @(posedge clk);
        #1;
        check({tag, "/par"},   {6'd0, paritybit},     {6'd0, e_par});
        check({tag, "/stop"},  {7'd0, stopbit},       {7'd0, e_stop});
        check({tag, "/ready"}, {7'd0, cfg_bus.c_ready}, {7'd0, e_ready});
`ifdef UART_CONFIG_ERR_EN
        check({tag, "/err"},   {7'd0, c_err},         {7'd0, e_err});
`else
        if (e_err === 1'bx) $display("unreachable");
`endif
        $display("step %-12s rst=%b v=%b a=%b d=%h -> par=%b stop=%b rdy=%b",
                 tag, r, v, a, d, paritybit, stopbit, cfg_bus.c_ready);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst             = 1'b1;
        cfg_bus.c_valid = 1'b0;
        cfg_bus.c_addr  = 2'b00;
        cfg_bus.c_data  = 8'h00;

        //    tag            rst   v     addr   data   par    stop  rdy   err
        step("reset0",       1'b1, 1'b0, 2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        step("reset1",       1'b1, 1'b0, 2'b00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        step("ready_up",     1'b0, 1'b0, 2'b00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
        // Wrong addresses are consumed without effect
        step("badaddr00",    1'b0, 1'b1, 2'b00, 8'hA0, 2'b00, 1'b0, 1'b1, 1'b1);
        step("badaddr11",    1'b0, 1'b1, 2'b11, 8'hA0, 2'b00, 1'b0, 1'b1, 1'b1);
        step("badaddr10",    1'b0, 1'b1, 2'b10, 8'hA0, 2'b00, 1'b0, 1'b1, 1'b1);
        // Back-to-back parity writes
        step("par_none",     1'b0, 1'b1, 2'b01, 8'hA0, 2'b00, 1'b0, 1'b1, 1'b0);
        step("par_odd",      1'b0, 1'b1, 2'b01, 8'h24, 2'b01, 1'b0, 1'b1, 1'b0);
        step("par_even",     1'b0, 1'b1, 2'b01, 8'h2A, 2'b10, 1'b0, 1'b1, 1'b0);
        // No valid, no change
        step("novalid",      1'b0, 1'b0, 2'b01, 8'h22, 2'b10, 1'b0, 1'b1, 1'b0);
        // Stop-bit writes
        step("stop2",        1'b0, 1'b1, 2'b01, 8'hC4, 2'b10, 1'b1, 1'b1, 1'b0);
        step("stop1",        1'b0, 1'b1, 2'b01, 8'h40, 2'b10, 1'b0, 1'b1, 1'b0);
        step("nowe",         1'b0, 1'b1, 2'b01, 8'h00, 2'b10, 1'b0, 1'b1, 1'b0);
        // Reserved parity and unknown address
        step("par_rsvd",     1'b0, 1'b1, 2'b01, 8'h2C, 2'b10, 1'b0, 1'b1, 1'b1);
        step("badaddr_22",   1'b0, 1'b1, 2'b10, 8'h22, 2'b10, 1'b0, 1'b1, 1'b1);
        // Wrong address must not touch stopbit either
        step("badaddr_C4",   1'b0, 1'b1, 2'b11, 8'hC4, 2'b10, 1'b0, 1'b1, 1'b1);
        // Both fields in one word
        step("both_E4",      1'b0, 1'b1, 2'b01, 8'hE4, 2'b01, 1'b1, 1'b1, 1'b0);
        // Reserved parity still applies the stop field
        step("rsvd_stop_6C", 1'b0, 1'b1, 2'b01, 8'h6C, 2'b01, 1'b0, 1'b1, 1'b1);
        // Reset wins over a simultaneous write
        step("rst_midop",    1'b1, 1'b1, 2'b01, 8'hEA, 2'b00, 1'b0, 1'b0, 1'b0);
        step("after_rst",    1'b0, 1'b0, 2'b01, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
        step("post_write",   1'b0, 1'b1, 2'b01, 8'hE8, 2'b10, 1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
